pwm_duty_ramp_ctrl: RTL
=======================

# pwm_duty_ramp_ctrl

Sequencer that drives the `duty` and `pwm_freq` inputs of the 0.1 %-resolution PWM generator. It accepts target-duty requests over a valid/ready handshake and ramps the applied duty toward the target in fixed steps at a fixed tick rate, so LEDs and motors never see abrupt duty jumps. It sits between the command/FSM layer (buttons, UART decoder) and the PWM generator instance.

## Interface
- `STEP_TICKS`, 100_000, clocks per ramp step (1 ms at 100 MHz); legal range ≥ 1.
- `STEP_SIZE`, 10, duty units (0.1 %) per step; legal range 1..1000.
- `DUTY_MAX`, 1000, full-scale duty (100.0 %).
- `FREQ_RST`, 1000, `pwm_freq` value after reset, in Hz.
- `clk`  in  1  system clock, 100 MHz.
- `reset_p`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_duty`  in  10  target duty, 0..1023.
- `req_freq`  in  14  PWM frequency for this request, in Hz.
- `abort`  in  1  stop the ramp and freeze the duty.
- `duty`  out  10  applied duty, registered; feeds the PWM `duty` input.
- `pwm_freq`  out  14  applied frequency, registered.
- `busy`  out  1  ramp in progress.
- `done`  out  1  one-cycle pulse when the target is reached.
- `err`  out  1  one-cycle pulse when a request is rejected.

## Operation
- Reset values: `duty`=0, `pwm_freq`=`FREQ_RST`, `busy`=0, `done`=0, `err`=0, state IDLE, tick counter 0, target 0.
- `req_ready` = (state==IDLE) & ~`reset_p`. It is combinational.
- A request is accepted when `req_valid` & `req_ready` are both high at a rising edge.
- States:
  - IDLE
    - On accept with `req_freq`==0: reject. Pulse `err`; `duty`, `pwm_freq` and target are unchanged; stay IDLE.
    - On accept of a valid request: latch the target and load `pwm_freq`<=`req_freq`. Clear the tick counter.
      - If target == `duty`: pulse `done` and stay IDLE.
      - Otherwise go to RAMP and set `busy`=1.
    - `abort` is ignored in IDLE.
  - RAMP
    - The tick counter counts 0..`STEP_TICKS`-1 and wraps.
    - At terminal count, `duty` moves toward the target by `STEP_SIZE`.
    - The step saturates at the target; it never overshoots.
    - On the edge where `duty` becomes the target: `done`=1 for that one cycle, `busy`=0, next state IDLE.
  - Abort in RAMP
    - `duty` freezes at its current value.
    - Next state IDLE, `busy`=0, no `done` pulse.
    - `abort` and terminal count in the same cycle: abort wins and no step is taken.
- Arithmetic uses 11-bit intermediates.
  - Up step: `duty`+`STEP_SIZE` ≥ target → target.
  - Down step: `duty` − target ≤ `STEP_SIZE` → target.
  - No wrap-around is permitted in either direction.
- `req_valid` held high during RAMP is not accepted. The requester must hold it until `req_ready` is high.
- `reset_p` asserted mid-ramp returns every register to its reset value on that edge.

## Timing
- Accept at edge N:
  - `pwm_freq` updates at edge N.
  - State is RAMP in cycle N+1.
  - First `duty` step at edge N+`STEP_TICKS`.
  - Subsequent steps every `STEP_TICKS` edges.
- Ramp length from duty d0 to target t: ceil(|t−d0| / `STEP_SIZE`) steps.
- `done` is asserted at the edge of the final step.
- `req_ready` rises in the cycle after `done`. Back-to-back requests therefore have one cycle of latency.
- `done` and `err` pulses are exactly one clock wide.
- `duty` changes only on step edges or reset. The PWM generator samples it continuously, and duty changes take effect at its next period boundary.

## Configuration
- `PWM_RAMP_CLAMP_EN` defined: accepted `req_duty` > `DUTY_MAX` is clamped to `DUTY_MAX` and processed normally. No `err` pulse.
- `PWM_RAMP_CLAMP_EN` undefined: accepted `req_duty` > `DUTY_MAX` is rejected.
  - Pulse `err`; `duty`, `pwm_freq` and target are unchanged; stay IDLE.
- `req_freq`==0 is rejected in both builds.

## Test plan
- Up ramp with `STEP_TICKS`=4, `STEP_SIZE`=10. From reset (`duty`=0) request 35 @ 1000 Hz.
  - `duty` = 10, 20, 30, 35 at edges N+4, N+8, N+12, N+16.
  - `done` pulses at N+16; `busy` 1→0 at N+16.
- Down ramp, no overshoot: from 35 request 0 → steps 25, 15, 5, 0; single `done`.
- Abort mid-ramp: abort at N+9 during a 0→500 ramp.
  - `duty` frozen at 20, IDLE, no `done`, `req_ready`=1 next cycle.
  - Abort coinciding with terminal count → no step.
- Reject cases:
  - `req_freq`=0 → `err` pulse; `duty` and `pwm_freq` unchanged.
  - `req_duty`=1023 with clamp defined → ramps to 1000, `done`, no `err`.
  - `req_duty`=1023 without clamp → `err` pulse only.
- Handshake and reset:
  - `req_valid` held through a ramp → accepted only after `done`.
  - Same-duty request → `done` pulse with no RAMP state.
  - `reset_p` asserted mid-ramp → `duty`=0, `pwm_freq`=1000, `busy`=0 at that edge.

Source files
------------

// File: rtl/pwm_duty_ramp_ctrl.sv
// pwm_duty_ramp_ctrl
//
// Purpose:
//   Sequencer in front of the 0.1 %-resolution PWM generator. Accepts a
//   target duty and PWM frequency over a valid/ready handshake, applies the
//   frequency immediately and walks the applied duty toward the target in
//   STEP_SIZE increments, one increment every STEP_TICKS clocks, so loads
//   never see an abrupt duty jump. An abort freezes the duty where it is.
//
// Configuration macro:
//   PWM_RAMP_CLAMP_EN  defined   -> req_duty above DUTY_MAX is clamped to
//                                   DUTY_MAX and ramped to normally.
//                      undefined -> req_duty above DUTY_MAX is rejected
//                                   with an err pulse.
//   A request with req_freq == 0 is rejected in both builds.
//
// Ports:
//   clk        in   1   system clock
//   reset_p    in   1   synchronous active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   controller idle and able to accept (combinational)
//   req_duty   in  10   target duty, 0.1 % units
//   req_freq   in  14   PWM frequency for this request, Hz
//   abort      in   1   stop an active ramp, freeze duty
//   duty       out 10   applied duty (registered)
//   pwm_freq   out 14   applied frequency (registered)
//   busy       out  1   ramp in progress
//   done       out  1   one-cycle pulse when the target is reached
//   err        out  1   one-cycle pulse when a request is rejected

module pwm_duty_ramp_ctrl #(
    parameter int STEP_TICKS = 100_000,
    parameter int STEP_SIZE  = 10,
    parameter int DUTY_MAX   = 1000,
    parameter int FREQ_RST   = 1000
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_duty,
    input  logic [13:0] req_freq,
    input  logic        abort,
    output logic [9:0]  duty,
    output logic [13:0] pwm_freq,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    // A single-tick step period still needs a one-bit counter that stays 0.
    localparam int             CW        = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(STEP_TICKS - 1);
    localparam logic [10:0]    STEP      = 11'(STEP_SIZE);
    localparam logic [9:0]     DMAX      = 10'(DUTY_MAX);

    state_t        state, state_n;
    logic [CW-1:0] tick_cnt, tick_n;
    logic [9:0]    target, target_n;
    logic [9:0]    duty_n;
    logic [13:0]   freq_n;
    logic          busy_n, done_n, err_n;

    logic [9:0]    duty_eff;
    logic          range_bad;
    logic [10:0]   up_sum;
    logic [10:0]   down_diff;
    logic [9:0]    step_val;

    assign req_ready = (state == IDLE) & ~reset_p;

    // Out-of-range targets are either pulled down to full scale or flagged
    // for rejection, depending on the build.
`ifdef PWM_RAMP_CLAMP_EN
    assign duty_eff  = (req_duty > DMAX) ? DMAX : req_duty;
    assign range_bad = 1'b0;
`else
    assign duty_eff  = req_duty;
    assign range_bad = (req_duty > DMAX);
`endif

    // Next duty value for one ramp step. The 11-bit sums keep duty+STEP from
    // wrapping; both directions land exactly on the target instead of
    // overshooting it.
    assign up_sum    = {1'b0, duty} + STEP;
    assign down_diff = {1'b0, duty} - {1'b0, target};

    always_comb begin
        step_val = target;
        if (target > duty) begin
            if (up_sum < {1'b0, target}) begin
                step_val = up_sum[9:0];
            end
        end else begin
            if (down_diff > STEP) begin
                step_val = duty - STEP[9:0];
            end
        end
    end

    // State and output registers; everything returns to its reset value on
    // a reset edge, including mid-ramp.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state    <= IDLE;
            tick_cnt <= '0;
            target   <= '0;
            duty     <= '0;
            pwm_freq <= 14'(FREQ_RST);
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            target   <= target_n;
            duty     <= duty_n;
            pwm_freq <= freq_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

    // Next-state logic. done/err default low so they can only be one-cycle
    // pulses. In RAMP an abort takes priority over a coincident step.
    always_comb begin
        state_n  = state;
        tick_n   = tick_cnt;
        target_n = target;
        duty_n   = duty;
        freq_n   = pwm_freq;
        busy_n   = busy;
        done_n   = 1'b0;
        err_n    = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if ((req_freq == 14'd0) || range_bad) begin
                        err_n = 1'b1;
                    end else begin
                        target_n = duty_eff;
                        freq_n   = req_freq;
                        tick_n   = '0;
                        if (duty_eff == duty) begin
                            done_n = 1'b1;
                        end else begin
                            state_n = RAMP;
                            busy_n  = 1'b1;
                        end
                    end
                end
            end
            RAMP: begin
                if (abort) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    tick_n  = '0;
                end else if (tick_cnt == TICK_LAST) begin
                    tick_n = '0;
                    duty_n = step_val;
                    if (step_val == target) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule
